// File: rtl/alu_pkg.sv
// Shared definitions for the ALU building blocks.
//   state_t       : control states of the bit-serial subtractor
//   DEFAULT_WIDTH : default operand/result width in bits
package alu_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : alu_pkg

// File: rtl/full_subtractor.sv
// One-bit full subtractor: computes num_1 - num_2 - b_in.
//   num_1 : minuend bit
//   num_2 : subtrahend bit
//   b_in  : borrow in from the less significant bit
//   diff  : difference bit
//   b_out : borrow out to the more significant bit
module full_subtractor (
  input  logic num_1,
  input  logic num_2,
  input  logic b_in,
  output logic diff,
  output logic b_out
);

  assign diff  = num_1 ^ num_2 ^ b_in;
  assign b_out = (~num_1 & num_2) | (~(num_1 ^ num_2) & b_in);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = num_1 - num_2 mod 2^WIDTH, one bit
// per clock, LSB first, through a single full_subtractor cell.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : begin a subtraction (accepted only when idle)
//   num_1  : minuend, captured with an accepted start
//   num_2  : subtrahend, captured with an accepted start
//   busy   : high during the WIDTH bit-processing cycles
//   done   : one-cycle pulse when diff/borrow/zero are updated
//   diff   : result, held until the next completion
//   borrow : final borrow out (num_1 < num_2)
//   zero   : diff == 0
module serial_subtractor
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] num_1,
  input  logic [WIDTH-1:0] num_2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             bin_q, bin_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             zero_q, zero_d;

  logic             fs_diff;
  logic             fs_bout;
  logic [WIDTH-1:0] res_shift;

  full_subtractor u_fs (
    .num_1 (a_q[0]),
    .num_2 (b_q[0]),
    .b_in  (bin_q),
    .diff  (fs_diff),
    .b_out (fs_bout)
  );

  // New difference bit enters at the MSB so that after WIDTH shifts the
  // first (LSB) result bit has arrived at position 0.
  assign res_shift = {fs_diff, res_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      bin_q    <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = num_1;
          b_d     = num_2;
          res_d   = '0;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        res_d = res_shift;
        bin_d = fs_bout;
        if (cnt_q == LAST) begin
          // Counter parks at zero instead of wrapping past LAST.
          cnt_d    = '0;
          diff_d   = res_shift;
          borrow_d = fs_bout;
          zero_d   = ~|res_shift;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign zero   = zero_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH = 8): directed corner
// cases, randomized operands, ignored start, mid-run reset and held start.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] num_1;
  logic [W-1:0] num_2;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         zero;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .num_1  (num_1),
    .num_2  (num_2),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},   32'(busy),   32'd0);
    check({tag, "_done"},   32'(done),   32'd0);
    check({tag, "_diff"},   32'(diff),   32'd0);
    check({tag, "_borrow"}, 32'(borrow), 32'd0);
    check({tag, "_zero"},   32'(zero),   32'd0);
  endtask

  // One operation from idle; inject_at >= 0 pulses a competing start
  // (0xFF - 0x00) partway through the run, which must be ignored.
  task automatic run_op(input logic [W-1:0] n1, input logic [W-1:0] n2, input int inject_at);
    logic [W-1:0] exp_diff;
    int cyc;
    int busy_cnt;
    int extra;
    exp_diff = n1 - n2;
    start = 1'b1;
    num_1 = n1;
    num_2 = n2;
    tick;
    start = 1'b0;
    num_1 = W'($urandom);
    num_2 = W'($urandom);
    cyc = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && cyc < 4 * W) begin
      if (busy === 1'b1) busy_cnt++;
      if (cyc == inject_at) begin
        start = 1'b1;
        num_1 = '1;
        num_2 = '0;
      end else begin
        start = 1'b0;
      end
      tick;
      cyc++;
    end
    start = 1'b0;
    check("latency",   32'(cyc),      32'(W));
    check("busy_cnt",  32'(busy_cnt), 32'(W));
    check("busy_done", 32'(busy),     32'd0);
    check("diff",      32'(diff),     32'(exp_diff));
    check("borrow",    32'(borrow),   32'(n1 < n2));
    check("zero",      32'(zero),     32'(n1 == n2));
    tick;
    check("done_pulse", 32'(done), 32'd0);
    if (inject_at >= 0) begin
      extra = 0;
      for (int i = 0; i < W + 2; i++) begin
        if (done === 1'b1 || busy === 1'b1) extra++;
        tick;
      end
      check("inject_extra", 32'(extra), 32'd0);
      check("inject_hold",  32'(diff),  32'(exp_diff));
    end
  endtask

  initial begin
    logic [W-1:0] h1 [30];
    logic [W-1:0] h2 [30];
    logic [W-1:0] last_diff;
    bit           have;
    bit           exp_busy;
    bit           exp_done;

    rst_n = 1'b0;
    start = 1'b0;
    num_1 = '0;
    num_2 = '0;
    tick;
    tick;
    check_outputs_zero("reset");
    rst_n = 1'b1;

    run_op(8'h5A, 8'h23, -1);
    run_op(8'h10, 8'h20, -1);
    run_op(8'h00, 8'hFF, -1);
    run_op(8'h42, 8'h42, -1);
    run_op(8'hFF, 8'hFF, -1);
    run_op(8'hFF, 8'h00, -1);
    run_op(8'h00, 8'h01, -1);
    for (int i = 0; i < 20; i++) begin
      run_op(W'($urandom), W'($urandom), -1);
    end

    // Competing start during the run is ignored.
    run_op(8'h5A, 8'h23, 2);

    // Reset in the middle of a run aborts it immediately.
    start = 1'b1;
    num_1 = 8'h10;
    num_2 = 8'h20;
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrun_reset");
    tick;
    check_outputs_zero("reset_hold");
    rst_n = 1'b1;
    // Start on the very first edge after release.
    run_op(8'h5A, 8'h23, -1);

    // Start held high: ops at every (W+2)th edge, operands captured then.
    have = 1'b0;
    last_diff = '0;
    for (int t = 0; t < 30; t++) begin
      num_1 = W'($urandom);
      num_2 = W'($urandom);
      h1[t] = num_1;
      h2[t] = num_2;
      start = 1'b1;
      tick;
      exp_busy = (t % (W + 2)) < W;
      exp_done = (t % (W + 2)) == W;
      check("hold_busy", 32'(busy), 32'(exp_busy));
      check("hold_done", 32'(done), 32'(exp_done));
      if (exp_done) begin
        last_diff = h1[t - W] - h2[t - W];
        have = 1'b1;
      end
      if (have) check("hold_diff", 32'(diff), 32'(last_diff));
    end
    start = 1'b0;
    for (int i = 0; i < W + 3; i++) tick;
    check("drain_busy", 32'(busy), 32'd0);
    check("drain_done", 32'(done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_serial_subtractor
